// File: rtl/pipe_reg_ex_mem_hs_if.sv
// EX -> MEM handshake bundle: EX-side entry with valid/ready, MEM-side held entry with valid/ready.
// master = the EX/MEM environment, slave = the pipeline register stage.
interface pipe_reg_ex_mem_hs_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned REG_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic              in_mem_write;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_W-1:0]  in_wreg;

  logic              out_valid;
  logic              out_ready;
  logic              out_reg_write;
  logic              out_mem_to_reg;
  logic              out_mem_write;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_wdata;
  logic [REG_W-1:0]  out_wreg;

  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_alu, in_wdata, in_wreg,
    output out_ready,
    input  in_ready,
    input  out_valid, out_reg_write, out_mem_to_reg, out_mem_write, out_alu, out_wdata, out_wreg
  );

  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_mem_write, in_alu, in_wdata, in_wreg,
    input  out_ready,
    output in_ready,
    output out_valid, out_reg_write, out_mem_to_reg, out_mem_write, out_alu, out_wdata, out_wreg
  );
endinterface

// File: rtl/pipe_reg_ex_mem_hs.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer, flush and async reset.
// Optional MEM back-pressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module pipe_reg_ex_mem_hs #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned REG_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_reg_ex_mem_hs_if.slave   bus,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } entry_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  // r_out_valid is the main-entry valid bit; !r_in_ready is the skid-entry valid bit
  logic   r_in_ready;
  logic   r_out_valid;

  entry_t w_in;
  logic   w_in_xfer;
  logic   w_out_xfer;

  assign w_in = '{reg_write:  bus.in_reg_write,
                  mem_to_reg: bus.in_mem_to_reg,
                  mem_write:  bus.in_mem_write,
                  alu:        bus.in_alu,
                  wdata:      bus.in_wdata,
                  wreg:       bus.in_wreg};

  assign w_in_xfer  = bus.in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & bus.out_ready;

  // Main-entry control bits are cleared whenever main goes invalid, so the
  // control outputs are gated by valid straight out of the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      {r_main.reg_write, r_main.mem_to_reg, r_main.mem_write} <= 3'b000;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= w_in;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_in;
          end else if (w_in_xfer) begin
            r_skid     <= w_in;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            {r_main.reg_write, r_main.mem_to_reg, r_main.mem_write} <= 3'b000;
          end
        end
        S_TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          {r_main.reg_write, r_main.mem_to_reg, r_main.mem_write} <= 3'b000;
        end
      endcase
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_reg_write  = r_main.reg_write;
  assign bus.out_mem_to_reg = r_main.mem_to_reg;
  assign bus.out_mem_write  = r_main.mem_write;
  assign bus.out_alu        = r_main.alu;
  assign bus.out_wdata      = r_main.wdata;
  assign bus.out_wreg       = r_main.wreg;

`ifdef EX_MEM_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles where MEM holds off a valid entry; only rst clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_ex_mem_hs.sv
// Self-checking bench for pipe_reg_ex_mem_hs: vector table, streaming, flush, async reset, stall counter.
module tb_pipe_reg_ex_mem_hs;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned REG_W  = 6;
  localparam int unsigned CNT_W  = 4;
`ifdef EX_MEM_STALL_CNT_EN
  localparam int unsigned EXP_SAT = 15;
`else
  localparam int unsigned EXP_SAT = 0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  pipe_reg_ex_mem_hs_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  pipe_reg_ex_mem_hs #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } sb_t;

  typedef struct {
    bit                iv;
    logic [DATA_W-1:0] alu;
    logic [2:0]        ctrl;
    bit                ordy;
    bit                fl;
    bit                e_ir;
    bit                e_ov;
    logic [2:0]        e_ctrl;
    logic [DATA_W-1:0] e_alu;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sb[$];
  int   exp_stall = 0;
  vec_t v[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input logic [DATA_W-1:0] alu, input logic [2:0] ctrl,
                       input bit ordy, input bit fl);
    bus.in_valid = iv;
    bus.in_alu   = alu;
    bus.in_wdata = ~alu;
    bus.in_wreg  = alu + REG_W'(3);
    {bus.in_reg_write, bus.in_mem_to_reg, bus.in_mem_write} = ctrl;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  function automatic vec_t mk(bit iv, logic [DATA_W-1:0] alu, logic [2:0] ctrl, bit ordy, bit fl,
                              bit e_ir, bit e_ov, logic [2:0] e_ctrl, logic [DATA_W-1:0] e_alu);
    vec_t r;
    r.iv = iv; r.alu = alu; r.ctrl = ctrl; r.ordy = ordy; r.fl = fl;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_ctrl = e_ctrl; r.e_alu = e_alu;
    return r;
  endfunction

  // Scoreboard and stall-counter model, evaluated mid-cycle ahead of the next edge
  always @(negedge clk) begin
    sb_t e;
    sb_t c;
    if (rst) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (!bus.out_valid)
        check("ctrl_gated", 32'({bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_write}), 32'd0);
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_alu", 32'(bus.out_alu), 32'(e.alu));
            check("sb_wdata", 32'(bus.out_wdata), 32'(e.wdata));
            check("sb_wreg", 32'(bus.out_wreg), 32'(e.wreg));
            check("sb_ctrl", 32'({bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_write}), 32'(e.ctrl));
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          c.ctrl  = {bus.in_reg_write, bus.in_mem_to_reg, bus.in_mem_write};
          c.alu   = bus.in_alu;
          c.wdata = bus.in_wdata;
          c.wreg  = bus.in_wreg;
          sb.push_back(c);
        end
      end
`ifdef EX_MEM_STALL_CNT_EN
      if (bus.out_valid && !bus.out_ready && exp_stall < 15) exp_stall++;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // vector table: inputs applied for one cycle, expected outputs seen in that same cycle
    v[0]  = mk(1, 6'd5,  3'b101, 0, 0,  1, 0, 3'b000, 6'd0);
    v[1]  = mk(1, 6'd6,  3'b010, 0, 0,  1, 1, 3'b101, 6'd5);
    v[2]  = mk(1, 6'd7,  3'b111, 0, 0,  0, 1, 3'b101, 6'd5);
    v[3]  = mk(1, 6'd7,  3'b111, 1, 0,  0, 1, 3'b101, 6'd5);
    v[4]  = mk(1, 6'd7,  3'b111, 1, 0,  1, 1, 3'b010, 6'd6);
    v[5]  = mk(0, 6'd0,  3'b000, 1, 0,  1, 1, 3'b111, 6'd7);
    v[6]  = mk(0, 6'd0,  3'b000, 1, 0,  1, 0, 3'b000, 6'd0);
    v[7]  = mk(1, 6'd1,  3'b100, 0, 0,  1, 0, 3'b000, 6'd0);
    v[8]  = mk(1, 6'd2,  3'b001, 0, 0,  1, 1, 3'b100, 6'd1);
    v[9]  = mk(1, 6'd9,  3'b100, 0, 1,  0, 1, 3'b100, 6'd1);
    v[10] = mk(0, 6'd0,  3'b000, 1, 0,  1, 0, 3'b000, 6'd0);
    v[11] = mk(1, 6'd3,  3'b011, 0, 0,  1, 0, 3'b000, 6'd0);
    v[12] = mk(1, 6'd10, 3'b111, 0, 1,  1, 1, 3'b011, 6'd3);
    v[13] = mk(0, 6'd0,  3'b000, 1, 0,  1, 0, 3'b000, 6'd0);

    rst = 1'b1;
    drive(0, 6'd0, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_fields", 32'({bus.out_alu, bus.out_wdata, bus.out_wreg}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_fields", 32'({bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_write,
                             bus.out_alu, bus.out_wdata, bus.out_wreg}), 32'd0);

    // back-to-back stream of 1..8 with MEM always ready: one-cycle latency, no bubbles
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      drive(i < 8, 6'(i + 1), 3'(i), 1, 0);
      @(negedge clk);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (i > 0) begin
        check("stream_out_valid", 32'(bus.out_valid), 32'd1);
        check("stream_out_alu", 32'(bus.out_alu), 32'(i));
      end
    end

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      drive(v[i].iv, v[i].alu, v[i].ctrl, v[i].ordy, v[i].fl);
      @(negedge clk);
      check("tbl_in_ready", 32'(bus.in_ready), 32'(v[i].e_ir));
      check("tbl_out_valid", 32'(bus.out_valid), 32'(v[i].e_ov));
      check("tbl_ctrl", 32'({bus.out_reg_write, bus.out_mem_to_reg, bus.out_mem_write}), 32'(v[i].e_ctrl));
      if (v[i].e_ov) check("tbl_out_alu", 32'(bus.out_alu), 32'(v[i].e_alu));
    end

    // asynchronous reset mid-cycle while holding a store
    @(posedge clk); #1;
    drive(1, 6'd4, 3'b001, 0, 0);
    @(posedge clk); #1;
    drive(0, 6'd0, 3'b000, 0, 0);
    @(negedge clk);
    check("pre_rst_mem_write", 32'(bus.out_mem_write), 32'd1);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_mem_write", 32'(bus.out_mem_write), 32'd0);
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_in_ready", 32'(bus.in_ready), 32'd1);
    check("async_out_alu", 32'(bus.out_alu), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // MEM stalls a valid entry for 20 cycles
    @(posedge clk); #1;
    drive(1, 6'd11, 3'b110, 0, 0);
    @(posedge clk); #1;
    drive(0, 6'd0, 3'b000, 0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stall_saturated", 32'(stall_cnt), 32'(EXP_SAT));
    @(posedge clk); #1;
    drive(0, 6'd0, 3'b000, 0, 1);
    @(posedge clk); #1;
    drive(0, 6'd0, 3'b000, 0, 0);
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_keeps_stall", 32'(stall_cnt), 32'(EXP_SAT));

    @(posedge clk); #1;
    drive(0, 6'd0, 3'b000, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
